// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the AXI UART controller.
package uart_pkg;

  localparam logic [2:0] DATA_OFS = 3'h0;
  localparam logic [2:0] STAT_OFS = 3'h4;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_TX_IDLE   = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two. A push on a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_phy.sv
// 8N1 serializer/deserializer with DIV clocks per bit; rx_in is synchronized
// here, so it may come straight from a pin.
module uart_phy #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  input  logic       rx_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  logic          tx_busy;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_load;
  logic          tx_shift;

  logic          rx_s1, rx_s2, rx_prev, rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          rx_take;

  assign tx_ready = !tx_busy;
  assign tx_load  = !tx_busy && tx_valid;
  assign tx_shift = tx_busy && (tx_cnt == '0) && (tx_bits != '0);
  assign rx_data  = rx_sh;
  assign rx_take  = rx_act && (rx_cnt == '0) && (rx_idx != 4'd0) && (rx_idx != 4'd9);

  // TX: start bit goes out the cycle after the byte is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_bits <= '0;
      tx_cnt  <= '0;
      tx_out  <= 1'b1;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_bits <= 4'd9;
      tx_cnt  <= DIV_M1;
      tx_out  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bits == '0) begin
        tx_busy <= 1'b0;
      end else begin
        tx_out  <= tx_sh[0];
        tx_bits <= tx_bits - 4'd1;
        tx_cnt  <= DIV_M1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load)       tx_sh <= {1'b1, tx_data};
    else if (tx_shift) tx_sh <= {1'b1, tx_sh[8:1]};
  end

  // RX: idx 0 = start bit check, 1..8 = data, 9 = stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_act    <= 1'b0;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx_in;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF_M1;
          rx_idx <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= DIV_M1;
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_idx == 4'd9) begin
          rx_act    <= 1'b0;
          rx_valid  <= rx_s2;
          frame_err <= !rx_s2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_take) rx_sh <= {rx_s2, rx_sh[7:1]};
  end

endmodule

// File: rtl/axi_uart_ctrl.sv
// AXI4 slave UART: data register at addr[2]=0, status at addr[2]=1.
// Define UART_LOOPBACK_EN to feed the TX serial stream back into RX (txd held high).
module axi_uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 150000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            txd,
  input  logic            rxd,
  input  logic [ID_W-1:0] io_uart_ar_id,
  input  logic [31:0]     io_uart_ar_addr,
  input  logic [7:0]      io_uart_ar_len,
  input  logic [2:0]      io_uart_ar_size,
  input  logic [1:0]      io_uart_ar_burst,
  input  logic            io_uart_ar_valid,
  output logic            io_uart_ar_ready,
  output logic [ID_W-1:0] io_uart_r_id,
  output logic [31:0]     io_uart_r_data,
  output logic [1:0]      io_uart_r_resp,
  output logic            io_uart_r_last,
  output logic            io_uart_r_valid,
  input  logic            io_uart_r_ready,
  input  logic [ID_W-1:0] io_uart_aw_id,
  input  logic [31:0]     io_uart_aw_addr,
  input  logic [7:0]      io_uart_aw_len,
  input  logic [2:0]      io_uart_aw_size,
  input  logic [1:0]      io_uart_aw_burst,
  input  logic            io_uart_aw_valid,
  output logic            io_uart_aw_ready,
  input  logic [31:0]     io_uart_w_data,
  input  logic [3:0]      io_uart_w_strb,
  input  logic            io_uart_w_last,
  input  logic            io_uart_w_valid,
  output logic            io_uart_w_ready,
  output logic [ID_W-1:0] io_uart_b_id,
  output logic [1:0]      io_uart_b_resp,
  output logic            io_uart_b_valid,
  input  logic            io_uart_b_ready
);
  localparam int DIV = CLK_FREQ / BAUD;

  rd_state_t rd_state;
  wr_state_t wr_state;
  logic [7:0]  rd_len, rd_beat;
  logic        rd_stat, rd_pop, r_hs;
  logic        wr_stat, w_to_tx, w_hs;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_ready, tx_line;
  logic [7:0]  tx_head, rx_head, phy_rx_data;
  logic        rx_pop, rx_full, rx_empty, phy_rx_valid, phy_ferr, phy_rx;
  logic        overrun, frame_err, ovr_set, stat_clr;
  logic [31:0] stat_word, data_word;
  logic        unused_in;

  assign unused_in = ^{io_uart_ar_addr[31:3], io_uart_ar_addr[1:0], io_uart_ar_size,
                       io_uart_ar_burst, io_uart_aw_addr[31:3], io_uart_aw_addr[1:0],
                       io_uart_aw_len, io_uart_aw_size, io_uart_aw_burst,
                       io_uart_w_data[31:8], io_uart_w_strb[3:1]};

`ifdef UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign phy_rx     = tx_line;
  assign txd        = 1'b1;
`else
  assign phy_rx     = rxd;
  assign txd        = tx_line;
`endif

  always_comb begin
    stat_word               = '0;
    stat_word[ST_TX_NFULL]  = !tx_full;
    stat_word[ST_RX_NEMPTY] = !rx_empty;
    stat_word[ST_OVERRUN]   = overrun;
    stat_word[ST_FRAME_ERR] = frame_err;
    stat_word[ST_TX_IDLE]   = tx_empty && tx_ready;
  end
  assign data_word = rx_empty ? 32'h0 : {24'h0, rx_head};

  assign io_uart_ar_ready = (rd_state == R_IDLE);
  assign io_uart_r_last   = (rd_state == R_DATA) && (rd_beat == rd_len);
  assign io_uart_r_resp   = RESP_OKAY;
  assign r_hs             = io_uart_r_valid && io_uart_r_ready;
  assign rx_pop           = r_hs && rd_pop;
  assign stat_clr         = r_hs && rd_stat;

  // Read beat data is snapshotted so it stays stable while r_ready is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state        <= R_IDLE;
      io_uart_r_valid <= 1'b0;
      io_uart_r_data  <= '0;
      io_uart_r_id    <= '0;
      rd_len          <= '0;
      rd_beat         <= '0;
      rd_stat         <= 1'b0;
      rd_pop          <= 1'b0;
    end else if (rd_state == R_IDLE) begin
      if (io_uart_ar_valid) begin
        rd_state        <= R_DATA;
        io_uart_r_id    <= io_uart_ar_id;
        rd_len          <= io_uart_ar_len;
        rd_beat         <= '0;
        rd_stat         <= (io_uart_ar_addr[2] == STAT_OFS[2]);
        io_uart_r_valid <= 1'b1;
        io_uart_r_data  <= (io_uart_ar_addr[2] == STAT_OFS[2]) ? stat_word : data_word;
        rd_pop          <= (io_uart_ar_addr[2] == DATA_OFS[2]) && !rx_empty;
      end
    end else if (r_hs) begin
      io_uart_r_valid <= 1'b0;
      rd_pop          <= 1'b0;
      if (rd_beat == rd_len) rd_state <= R_IDLE;
      else                   rd_beat  <= rd_beat + 8'd1;
    end else if (!io_uart_r_valid) begin
      io_uart_r_valid <= 1'b1;
      io_uart_r_data  <= rd_stat ? stat_word : data_word;
      rd_pop          <= !rd_stat && !rx_empty;
    end
  end

  assign io_uart_aw_ready = (wr_state == W_IDLE);
  assign io_uart_b_valid  = (wr_state == W_RESP);
  assign io_uart_b_resp   = RESP_OKAY;
  assign w_to_tx          = !wr_stat && io_uart_w_strb[0];
  assign io_uart_w_ready  = (wr_state == W_DATA) && (!w_to_tx || !tx_full);
  assign w_hs             = io_uart_w_valid && io_uart_w_ready;
  assign tx_push          = w_hs && w_to_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= W_IDLE;
      io_uart_b_id <= '0;
      wr_stat      <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (io_uart_aw_valid) begin
          wr_state     <= W_DATA;
          io_uart_b_id <= io_uart_aw_id;
          wr_stat      <= (io_uart_aw_addr[2] == STAT_OFS[2]);
        end
        W_DATA:  if (w_hs && io_uart_w_last) wr_state <= W_RESP;
        W_RESP:  if (io_uart_b_ready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // A fresh event in the clearing cycle keeps its sticky bit set
  assign ovr_set = phy_rx_valid && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  || (overrun   && !stat_clr);
      frame_err <= phy_ferr || (frame_err && !stat_clr);
    end
  end

  assign tx_pop = tx_ready && !tx_empty;

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(io_uart_w_data[7:0]),
    .pop(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(phy_rx_valid), .din(phy_rx_data),
    .pop(rx_pop), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_phy #(.DIV(DIV)) u_phy (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(!tx_empty), .tx_data(tx_head), .tx_ready(tx_ready), .tx_out(tx_line),
    .rx_in(phy_rx), .rx_valid(phy_rx_valid), .rx_data(phy_rx_data), .frame_err(phy_ferr)
  );

endmodule

// File: tb/tb_axi_uart_ctrl.sv
// Directed bench for axi_uart_ctrl with a short bit period (DIV=16) and 4-entry FIFOs.
module tb_axi_uart_ctrl;
  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DIV      = 16;
  localparam int DEPTH    = 4;
  localparam int ID_W     = 8;
  localparam logic [31:0] A_DATA = 32'hBFD003F8;
  localparam logic [31:0] A_STAT = 32'hBFD003FC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;
  logic rxd = 1'b1;
  logic [ID_W-1:0] ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [ID_W-1:0] r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid;
  logic        r_ready = 1'b0;
  logic [ID_W-1:0] aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int tx_bad = 0;
  logic [7:0] tx_got[$];

  axi_uart_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .txd(txd), .rxd(rxd),
    .io_uart_ar_id(ar_id), .io_uart_ar_addr(ar_addr), .io_uart_ar_len(ar_len),
    .io_uart_ar_size(ar_size), .io_uart_ar_burst(ar_burst), .io_uart_ar_valid(ar_valid),
    .io_uart_ar_ready(ar_ready),
    .io_uart_r_id(r_id), .io_uart_r_data(r_data), .io_uart_r_resp(r_resp),
    .io_uart_r_last(r_last), .io_uart_r_valid(r_valid), .io_uart_r_ready(r_ready),
    .io_uart_aw_id(aw_id), .io_uart_aw_addr(aw_addr), .io_uart_aw_len(aw_len),
    .io_uart_aw_size(aw_size), .io_uart_aw_burst(aw_burst), .io_uart_aw_valid(aw_valid),
    .io_uart_aw_ready(aw_ready),
    .io_uart_w_data(w_data), .io_uart_w_strb(w_strb), .io_uart_w_last(w_last),
    .io_uart_w_valid(w_valid), .io_uart_w_ready(w_ready),
    .io_uart_b_id(b_id), .io_uart_b_resp(b_resp), .io_uart_b_valid(b_valid),
    .io_uart_b_ready(b_ready)
  );

  always #5 clk = ~clk;

  // Independent 8N1 decoder on txd; glitches shorter than half a bit are ignored
  initial begin
    logic [7:0] mb;
    forever begin
      @(negedge txd);
      repeat (DIV / 2) @(posedge clk);
      #1;
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          mb[i] = txd;
        end
        repeat (DIV) @(posedge clk);
        #1;
        if (txd === 1'b1) tx_got.push_back(mb);
        else tx_bad++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] data, input logic [3:0] strb,
                           input logic [7:0] id, input bit wait_b, output int stalls,
                           output int blat, output logic [1:0] resp, output logic [7:0] bid,
                           output bit to);
    int n;
    to = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) to = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data = {24'hA5A5A5, data}; w_strb = strb; w_last = 1'b1; w_valid = 1'b1;
    n = 0;
    while (!w_ready && n < 3000) begin @(posedge clk); #1; n++; end
    stalls = n;
    if (n >= 3000) to = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
    n = 1;
    while (!b_valid && n < 100) begin @(posedge clk); #1; n++; end
    blat = n; resp = b_resp; bid = b_id;
    if (n >= 100) to = 1'b1;
    if (wait_b) begin
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, output logic [31:0] data,
                          output logic last, output logic [1:0] resp, output logic [7:0] rid,
                          output int lat, output bit to);
    int n;
    to = 1'b0;
    ar_id = id; ar_addr = addr; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01; ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) to = 1'b1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    n = 1;
    while (!r_valid && n < 100) begin @(posedge clk); #1; n++; end
    lat = n;
    if (n >= 100) to = 1'b1;
    data = r_data; last = r_last; resp = r_resp; rid = r_id;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(posedge clk); #1;
    end
    rxd = stop;
    repeat (DIV) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (DIV) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic l; logic [1:0] rs; logic [7:0] ri; int lat; bit to;
    repeat (3) @(posedge clk); #1;
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
    tests++; if (ar_ready !== 1'b1) begin fails++; $display("FAIL reset_ar_ready: got %b want 1", ar_ready); end
    tests++; if (aw_ready !== 1'b1) begin fails++; $display("FAIL reset_aw_ready: got %b want 1", aw_ready); end
    tests++; if (w_ready !== 1'b0) begin fails++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
    tests++; if (r_valid !== 1'b0 || r_last !== 1'b0) begin fails++; $display("FAIL reset_r: valid %b last %b want 0 0", r_valid, r_last); end
    tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL reset_r_data: got %h want 0", r_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(A_STAT, 8'h01, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL reset_status: got %h (timeout %0d) want 11", d, to); end
  endtask

  task automatic test_tx_frame();
    int st, bl, n; logic [1:0] rs; logic [7:0] bi; bit to;
    int errs [10];
    logic [9:0] frame;
    axi_write(A_DATA, 8'h41, 4'hF, 8'h12, 1'b1, st, bl, rs, bi, to);
    tests++; if (to) begin fails++; $display("FAIL tx_write_timeout: got timeout want handshake"); end
    tests++; if (bl !== 1) begin fails++; $display("FAIL tx_b_latency: got %0d want 1", bl); end
    tests++; if (rs !== 2'b00 || bi !== 8'h12) begin fails++; $display("FAIL tx_b_fields: resp %b id %h want 00 12", rs, bi); end
    frame = {1'b1, 8'h41, 1'b0};
    n = 0;
    while (txd !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (n >= 100) begin fails++; $display("FAIL tx_start_seen: no start bit in %0d cycles", n); end
    for (int b = 0; b < 10; b++) errs[b] = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (txd !== frame[k / DIV]) errs[k / DIV]++;
    end
    for (int b = 0; b < 10; b++) begin
      tests++;
      if (errs[b] != 0) begin fails++; $display("FAIL tx_bit%0d: %0d of %0d cycles not %b", b, errs[b], DIV, frame[b]); end
    end
  endtask

  task automatic test_rx_read();
    logic [31:0] d; logic l; logic [1:0] rs; logic [7:0] ri; int lat; bit to;
    send_frame(8'h5A, 1'b1);
    axi_read(A_STAT, 8'h21, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h13) begin fails++; $display("FAIL rx_status_full: got %h want 13", d); end
    axi_read(A_DATA, 8'h22, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h5A) begin fails++; $display("FAIL rx_data: got %h want 5a", d); end
    tests++; if (l !== 1'b1 || rs !== 2'b00 || ri !== 8'h22) begin fails++; $display("FAIL rx_r_fields: last %b resp %b id %h want 1 00 22", l, rs, ri); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL rx_r_latency: got %0d want 1", lat); end
    axi_read(A_STAT, 8'h23, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL rx_status_empty: got %h want 11", d); end
  endtask

  task automatic test_back_to_back();
    int st, bl, n, early, last_st; logic [1:0] rs; logic [7:0] bi; bit to, to_any;
    logic [31:0] d; logic l; logic [7:0] ri; int lat;
    tx_got.delete();
    tx_bad = 0; early = 0; last_st = 0; to_any = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      axi_write(A_DATA, 8'(8'hC0 + i), 4'hF, 8'(i), 1'b1, st, bl, rs, bi, to);
      if (to) to_any = 1'b1;
      if (i < DEPTH + 1) early += st;
      else last_st = st;
    end
    tests++; if (to_any) begin fails++; $display("FAIL b2b_timeout: got timeout want none"); end
    tests++; if (early != 0) begin fails++; $display("FAIL b2b_early_stall: got %0d stall cycles want 0", early); end
    tests++; if (last_st == 0) begin fails++; $display("FAIL b2b_backpressure: got %0d stall cycles want >0", last_st); end
    n = 0;
    while (tx_got.size() < DEPTH + 2 && n < 4000) begin @(posedge clk); #1; n++; end
    tests++; if (tx_got.size() != DEPTH + 2) begin fails++; $display("FAIL b2b_count: got %0d bytes want %0d", tx_got.size(), DEPTH + 2); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      tests++;
      if (i >= tx_got.size() || tx_got[i] !== 8'(8'hC0 + i)) begin
        fails++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < tx_got.size()) ? tx_got[i] : 8'hxx, 8'(8'hC0 + i));
      end
    end
    tests++; if (tx_bad != 0) begin fails++; $display("FAIL b2b_stop_bits: got %0d bad frames want 0", tx_bad); end
    repeat (DIV) @(posedge clk); #1;
    axi_read(A_STAT, 8'h30, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL b2b_status: got %h want 11", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic l; logic [1:0] rs; logic [7:0] ri; int lat; bit to;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'(8'h10 + i), 1'b1);
    axi_read(A_STAT, 8'h40, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h17) begin fails++; $display("FAIL ovr_status: got %h want 17", d); end
    axi_read(A_STAT, 8'h41, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h13) begin fails++; $display("FAIL ovr_cleared: got %h want 13", d); end
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(A_DATA, 8'h42, d, l, rs, ri, lat, to);
      tests++;
      if (to || d !== {24'h0, 8'(8'h10 + i)}) begin fails++; $display("FAIL ovr_data%0d: got %h want %h", i, d, 8'(8'h10 + i)); end
    end
    axi_read(A_STAT, 8'h43, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL ovr_drained: got %h want 11", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d; logic l; logic [1:0] rs; logic [7:0] ri; int lat; bit to;
    send_frame(8'h33, 1'b0);
    axi_read(A_STAT, 8'h50, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h19) begin fails++; $display("FAIL ferr_status: got %h want 19", d); end
    axi_read(A_DATA, 8'h51, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h0 || l !== 1'b1) begin fails++; $display("FAIL ferr_empty_read: data %h last %b want 0 1", d, l); end
    axi_read(A_STAT, 8'h52, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL ferr_cleared: got %h want 11", d); end
  endtask

  task automatic test_reset_mid();
    int st, bl, n; logic [1:0] rs; logic [7:0] bi; bit to;
    logic [31:0] d; logic l; logic [7:0] ri; int lat;
    axi_write(A_DATA, 8'h00, 4'hF, 8'h77, 1'b0, st, bl, rs, bi, to);
    tests++; if (to || bl !== 1) begin fails++; $display("FAIL rstmid_b_latency: got %0d want 1", bl); end
    n = 0;
    while (txd !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (b_valid !== 1'b1 || txd !== 1'b0) begin fails++; $display("FAIL rstmid_stall: b_valid %b txd %b want 1 0", b_valid, txd); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (b_valid !== 1'b0 || txd !== 1'b1) begin fails++; $display("FAIL rstmid_async: b_valid %b txd %b want 0 1", b_valid, txd); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (aw_ready !== 1'b1 || b_valid !== 1'b0) begin fails++; $display("FAIL rstmid_release: aw_ready %b b_valid %b want 1 0", aw_ready, b_valid); end
    axi_read(A_STAT, 8'h60, d, l, rs, ri, lat, to);
    tests++; if (to || d !== 32'h11) begin fails++; $display("FAIL rstmid_status: got %h want 11", d); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_read();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
